// File: rtl/turf_scaler_bank.sv
// Trigger-rate scaler bank: saturating per-channel edge counters, deadtime and PPS
// counters, all latched on PPS and read back through a registered 32-bit port.
module turf_scaler_bank #(
  parameter int NUM_CH = 64,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              pps_i,
  input  logic              busy_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic              rd_valid_o,
  output logic              update_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] sync1_q, sync2_q, edge_q;
  logic [NUM_CH-1:0] sat_q, sat_d, hold_sat_q, hold_sat_d;
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  hold_q [NUM_CH];
  logic [CNT_W-1:0]  hold_d [NUM_CH];
  logic              pps_dly_q;
  logic [31:0]       dt_q, dt_d, dt_hold_q, dt_hold_d;
  logic [15:0]       pps_cnt_q, pps_cnt_d, pps_hold_q, pps_hold_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, update_q;
  logic [NUM_CH-1:0] ev;
  logic              pps_edge;

  // Only unmasked events ever reach the counters, so masking freezes without clearing.
  assign ev       = sync2_q & ~edge_q & ~ch_mask_i;
  assign pps_edge = pps_i & ~pps_dly_q;

  always_comb begin
    sat_d      = sat_q;
    hold_sat_d = hold_sat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      hold_d[i] = hold_q[i];
      if (pps_edge) begin
        hold_d[i]     = cnt_q[i];
        hold_sat_d[i] = sat_q[i];
        cnt_d[i]      = ev[i] ? CNT_W'(1) : '0;
        sat_d[i]      = 1'b0;
      end else if (ev[i]) begin
        if (cnt_q[i] == CNT_MAX) sat_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    dt_d       = dt_q;
    dt_hold_d  = dt_hold_q;
    pps_cnt_d  = pps_cnt_q;
    pps_hold_d = pps_hold_q;
    if (pps_edge) begin
      dt_hold_d  = dt_q;
      dt_d       = {31'b0, busy_i};
      pps_cnt_d  = pps_cnt_q + 16'd1;
      pps_hold_d = pps_cnt_q + 16'd1;
    end else if (busy_i && (dt_q != 32'hFFFF_FFFF)) begin
      dt_d = dt_q + 32'd1;
    end
  end

  // Reads see the hold registers before any same-cycle PPS update.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr_i == ADDR_W'(i)) begin
          rd_data_d     = 32'(hold_q[i]);
          rd_data_d[31] = hold_sat_q[i];
        end
      end
      if (rd_addr_i == ADDR_W'(NUM_CH))     rd_data_d = dt_hold_q;
      if (rd_addr_i == ADDR_W'(NUM_CH + 1)) rd_data_d = {pps_hold_q, 15'b0, |hold_sat_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      edge_q     <= '0;
      sat_q      <= '0;
      hold_sat_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      pps_dly_q  <= 1'b0;
      dt_q       <= '0;
      dt_hold_q  <= '0;
      pps_cnt_q  <= '0;
      pps_hold_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      sync1_q    <= trig_i;
      sync2_q    <= sync1_q;
      edge_q     <= sync2_q;
      sat_q      <= sat_d;
      hold_sat_q <= hold_sat_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      pps_dly_q  <= pps_i;
      dt_q       <= dt_d;
      dt_hold_q  <= dt_hold_d;
      pps_cnt_q  <= pps_cnt_d;
      pps_hold_q <= pps_hold_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      update_q   <= pps_edge;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign update_o   = update_q;
endmodule

// File: tb/tb_turf_scaler_bank.sv
// Bench for turf_scaler_bank: directed stimulus, a cycle model of the counting rules,
// and literal expectations on the read-back values.
module tb_turf_scaler_bank;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NUM_CH-1:0] trig_i = '0;
  logic [NUM_CH-1:0] ch_mask_i = '0;
  logic              pps_i = 1'b0;
  logic              busy_i = 1'b0;
  logic              rd_en_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [31:0]       rd_data_o;
  logic              rd_valid_o;
  logic              update_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  turf_scaler_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i), .ch_mask_i(ch_mask_i),
    .pps_i(pps_i), .busy_i(busy_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .update_o(update_o)
  );

  // Model state: counts as plain integers, trig samples from previous edges.
  int unsigned       m_cnt [NUM_CH];
  int unsigned       m_hold [NUM_CH];
  bit                m_sat [NUM_CH];
  bit                m_hsat [NUM_CH];
  longint unsigned   m_dt = 0, m_dt_hold = 0;
  int unsigned       m_pps = 0, m_pps_hold = 0;
  logic [NUM_CH-1:0] m_hist [3];
  bit                m_pps_prev = 0, m_valid = 0, m_upd = 0, m_pe = 0;
  logic [31:0]       m_data = '0;
  logic [NUM_CH-1:0] m_ev;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(int a);
    logic [31:0] r = '0;
    bit any = 0;
    for (int i = 0; i < NUM_CH; i++) any |= m_hsat[i];
    if (a < NUM_CH)           r = (32'(m_hsat[a]) << 31) | m_hold[a];
    else if (a == NUM_CH)     r = m_dt_hold[31:0];
    else if (a == NUM_CH + 1) r = (m_pps_hold << 16) | 32'(any);
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_hold[i] = 0; m_sat[i] = 0; m_hsat[i] = 0;
      end
      for (int k = 0; k < 3; k++) m_hist[k] = '0;
      m_dt = 0; m_dt_hold = 0; m_pps = 0; m_pps_hold = 0;
      m_pps_prev = 0; m_valid = 0; m_upd = 0; m_data = '0;
    end else begin
      m_pe = pps_i && !m_pps_prev;
      m_valid = rd_en_i;
      if (rd_en_i) m_data = m_read(int'(rd_addr_i));
      // a rising trig level seen two edges ago counts at this edge
      m_ev = m_hist[1] & ~m_hist[2] & ~ch_mask_i;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_pe) begin
          m_hold[i] = m_cnt[i]; m_hsat[i] = m_sat[i];
          m_cnt[i] = m_ev[i] ? 1 : 0; m_sat[i] = 0;
        end else if (m_ev[i]) begin
          if (m_cnt[i] == (1 << CNT_W) - 1) m_sat[i] = 1;
          else m_cnt[i]++;
        end
      end
      if (m_pe) begin
        m_dt_hold = m_dt; m_dt = busy_i;
        m_pps = (m_pps + 1) % 65536; m_pps_hold = m_pps;
      end else if (busy_i && m_dt < 64'hFFFF_FFFF) begin
        m_dt++;
      end
      m_upd = m_pe;
      m_pps_prev = pps_i;
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = trig_i;
    end
  end

  always @(negedge clk_i) begin
    check("rd_valid", {31'b0, rd_valid_o}, {31'b0, m_valid});
    check("update", {31'b0, update_o}, {31'b0, m_upd});
    check("rd_data", rd_data_o, m_data);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse(int ch, int n);
    repeat (n) begin
      trig_i[ch] = 1'b1; tick(2);
      trig_i[ch] = 1'b0; tick(2);
    end
  endtask

  task automatic do_pps();
    int k = 0;
    pps_i = 1'b1;
    while (update_o !== 1'b1 && k < 8) begin tick(1); k++; end
    check("pps_update_seen", {31'b0, update_o}, 32'd1);
    pps_i = 1'b0;
    tick(2);
  endtask

  task automatic rd(int a, logic [31:0] exp, string name);
    rd_en_i = 1'b1; rd_addr_i = ADDR_W'(a);
    tick(1);
    rd_en_i = 1'b0;
    check({name, "_valid"}, {31'b0, rd_valid_o}, 32'd1);
    check(name, rd_data_o, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(1); rst_i = 1'b0;
  endtask

  initial begin
    tick(2);
    rst_i = 1'b0;
    check("reset_data", rd_data_o, 32'h0);

    // five pulses on channel 3
    pulse(3, 5);
    do_pps();
    rd(3, 32'h0000_0005, "ch3_count");
    for (int c = 0; c < NUM_CH; c++) if (c != 3) rd(c, 32'h0, "other_ch_zero");
    for (int a = 0; a < 16; a++) begin
      rd_en_i = 1'b1; rd_addr_i = ADDR_W'(a); tick(1);
    end
    rd_en_i = 1'b0;

    // saturation
    pulse(0, 20);
    do_pps();
    rd(0, 32'h8000_000F, "ch0_sat");
    rd(NUM_CH + 1, 32'h0002_0001, "pps_any_sat");
    do_pps();
    rd(0, 32'h0, "ch0_cleared");

    // event coinciding with the PPS edge goes into the next interval
    pulse(1, 7);
    trig_i[1] = 1'b1;
    tick(2);
    do_pps();
    trig_i[1] = 1'b0;
    tick(2);
    rd(1, 32'h0000_0007, "ch1_pre_edge");
    do_pps();
    rd(1, 32'h0000_0001, "ch1_carry");

    // deadtime and PPS counter
    do_reset();
    busy_i = 1'b1; tick(100); busy_i = 1'b0;
    do_pps();
    rd(NUM_CH, 32'd100, "deadtime");
    do_pps();
    do_pps();
    rd(NUM_CH + 1, 32'h0003_0000, "pps_three");
    rd(NUM_CH, 32'h0, "deadtime_idle");

    // masking freezes counting
    ch_mask_i[2] = 1'b1;
    pulse(2, 4);
    ch_mask_i[2] = 1'b0;
    pulse(2, 2);
    do_pps();
    rd(2, 32'h0000_0002, "ch2_masked");
    rd(NUM_CH + 5, 32'h0, "unmapped");
    tick(1);
    check("valid_drop", {31'b0, rd_valid_o}, 32'd0);
    check("data_hold", rd_data_o, 32'h0);

    // reset mid-interval discards partial counts
    do_reset();
    pulse(0, 9);
    do_reset();
    pulse(0, 1);
    do_pps();
    rd(0, 32'h0000_0001, "post_reset_count");
    rd(NUM_CH + 1, 32'h0001_0000, "post_reset_pps");

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
